// File: rtl/haar_pkg.sv
// Shared types and width derivations for the weighted Haar-feature accumulator.
package haar_pkg;
  localparam int W_DATA_DEF   = 18;
  localparam int W_WEIGHT_DEF = 3;
  localparam int MAX_RECT_DEF = 3;
  localparam int W_SHIFT_DEF  = 12;

  typedef enum logic [1:0] {CORNER_A, CORNER_B, CORNER_C, CORNER_D} corner_t;

  // Bit i set means corner i is subtracted: A - B + C - D.
  localparam logic [3:0] CORNER_NEG = 4'b1010;

  function automatic int w_rs(input int w_data);
    return w_data + 2;
  endfunction

  function automatic int w_nrect(input int max_rect);
    return $clog2(max_rect + 1);
  endfunction

  function automatic int w_facc(input int w_data, input int w_weight, input int max_rect);
    return w_data + 2 + w_weight + $clog2(max_rect + 1);
  endfunction

  function automatic int w_dout(input int w_data, input int w_weight, input int max_rect,
                                input int w_shift);
    return w_data + 2 + w_weight + $clog2(max_rect + 1) + w_shift;
  endfunction
endpackage

// File: rtl/haar_rect_acc.sv
// Corner counter and signed rectangle-sum accumulation; strobes on the corner-D transfer.
module haar_rect_acc
  import haar_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  localparam int W_RS  = W_DATA + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   xfer_i,
  input  logic [W_DATA-1:0]      din_i,
  output corner_t                cnt_o,
  output logic signed [W_RS-1:0] rs_o,
  output logic                   done_o
);
  corner_t                cnt_q, cnt_d;
  logic signed [W_RS-1:0] rs_q, rs_d;
  logic signed [W_RS-1:0] base, term;

  always_comb begin
    base  = (cnt_q == CORNER_A) ? '0 : rs_q;
    term  = W_RS'($signed({1'b0, din_i}));
    rs_d  = CORNER_NEG[cnt_q] ? (base - term) : (base + term);
    cnt_d = corner_t'(cnt_q + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CORNER_A;
      rs_q  <= '0;
    end else if (xfer_i) begin
      cnt_q <= cnt_d;
      rs_q  <= rs_d;
    end
  end

  // rs_o carries the completed A-B+C-D value in the corner-D cycle.
  assign cnt_o  = cnt_q;
  assign rs_o   = rs_d;
  assign done_o = xfer_i && (cnt_q == CORNER_D);
endmodule

// File: rtl/haar_feature_sum.sv
// Weights each rectangle sum, accumulates up to MAX_RECT rectangles per feature and
// presents the scaled result on a registered valid/ready port.
module haar_feature_sum
  import haar_pkg::*;
#(
  parameter int W_DATA   = W_DATA_DEF,
  parameter int W_WEIGHT = W_WEIGHT_DEF,
  parameter int MAX_RECT = MAX_RECT_DEF,
  parameter int W_SHIFT  = W_SHIFT_DEF,
  localparam int W_RS    = w_rs(W_DATA),
  localparam int W_NR    = w_nrect(MAX_RECT),
  localparam int W_FACC  = w_facc(W_DATA, W_WEIGHT, MAX_RECT),
  localparam int W_DOUT  = w_dout(W_DATA, W_WEIGHT, MAX_RECT, W_SHIFT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic [W_DATA-1:0]        din_data,
  input  logic                     din_last,
  input  logic                     weight_valid,
  output logic                     weight_ready,
  input  logic signed [W_WEIGHT-1:0] weight,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic signed [W_DOUT-1:0] dout_data,
  output logic [W_NR-1:0]          dout_nrect,
  output logic                     err
);
  localparam int W_PROD = W_WEIGHT + W_RS;

  corner_t                  cnt;
  logic signed [W_RS-1:0]   rs;
  logic                     rect_done, xfer, end_cond;
  logic signed [W_PROD-1:0] prod;
  logic signed [W_FACC-1:0] facc_q, facc_d, facc_sum;
  logic [W_NR-1:0]          rcnt_q, rcnt_d;
  logic                     dout_valid_q, dout_valid_d, err_q, err_d;
  logic signed [W_DOUT-1:0] dout_data_q, dout_data_d;
  logic [W_NR-1:0]          dout_nrect_q, dout_nrect_d;

  haar_rect_acc #(.W_DATA(W_DATA)) u_rect (
    .clk   (clk),
    .rst   (rst),
    .xfer_i(xfer),
    .din_i (din_data),
    .cnt_o (cnt),
    .rs_o  (rs),
    .done_o(rect_done)
  );

  // Only a feature-ending corner D needs the output slot free.
  assign end_cond     = din_last || (rcnt_q == W_NR'(MAX_RECT - 1));
  assign din_ready    = (cnt != CORNER_D) ||
                        (weight_valid && (!end_cond || !dout_valid_q || dout_ready));
  assign xfer         = din_valid && din_ready;
  assign weight_ready = din_valid && (cnt == CORNER_D) && din_ready;

  always_comb begin
    prod         = W_PROD'(weight) * W_PROD'(rs);
    facc_sum     = facc_q + W_FACC'(prod);
    facc_d       = facc_q;
    rcnt_d       = rcnt_q;
    dout_valid_d = dout_valid_q && !dout_ready;
    dout_data_d  = dout_data_q;
    dout_nrect_d = dout_nrect_q;
    err_d        = err_q || (xfer && (cnt != CORNER_D) && din_last);
    if (rect_done) begin
      if (end_cond) begin
        facc_d       = '0;
        rcnt_d       = '0;
        dout_valid_d = 1'b1;
        dout_data_d  = W_DOUT'(facc_sum) <<< W_SHIFT;
        dout_nrect_d = rcnt_q + W_NR'(1);
      end else begin
        facc_d = facc_sum;
        rcnt_d = rcnt_q + W_NR'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      facc_q       <= '0;
      rcnt_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_nrect_q <= '0;
      err_q        <= 1'b0;
    end else begin
      facc_q       <= facc_d;
      rcnt_q       <= rcnt_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      dout_nrect_q <= dout_nrect_d;
      err_q        <= err_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign dout_nrect = dout_nrect_q;
  assign err        = err_q;
endmodule

// File: tb/tb_haar_feature_sum.sv
// Directed bench for haar_feature_sum: rectangle table plus handshake corner cases.
module tb_haar_feature_sum;
  import haar_pkg::*;

  localparam int W_DOUT = 37;
  localparam int W_NR   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     din_valid, din_ready, din_last;
  logic [17:0]              din_data;
  logic                     weight_valid, weight_ready;
  logic signed [2:0]        weight;
  logic                     dout_valid, dout_ready;
  logic signed [W_DOUT-1:0] dout_data;
  logic [W_NR-1:0]          dout_nrect;
  logic                     err;

  int tests = 0;
  int fails = 0;

  haar_feature_sum dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .din_data    (din_data),
    .din_last    (din_last),
    .weight_valid(weight_valid),
    .weight_ready(weight_ready),
    .weight      (weight),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_data   (dout_data),
    .dout_nrect  (dout_nrect),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     c[4];
    int     w;
    bit     last;
    bit     out;
    longint exp_data;
    int     exp_nrect;
  } rect_vec_t;

  typedef struct {
    longint data;
    int     nrect;
  } result_t;

  result_t exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: every accepted output must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got data %0d nrect %0d, expected none",
                 longint'(dout_data), dout_nrect);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("dout_data", longint'(dout_data), e.data);
        check("dout_nrect", longint'(dout_nrect), longint'(e.nrect));
      end
    end
  end

  // Drive one corner and return just after the edge that transferred it.
  task automatic send_corner(input int data, input bit last);
    int n;
    din_valid = 1'b1;
    din_data  = 18'(data);
    din_last  = last;
    n = 0;
    @(negedge clk);
    while (!din_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL corner_timeout: din_ready stuck at %0b, required 1", din_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("drain_pending", longint'(exp_q.size()), 0);
  endtask

  rect_vec_t vecs[9];

  initial begin
    longint held;
    vecs[0] = '{c:'{100, 40, 10, 30}, w:-1, last:1, out:1, exp_data:-163840, exp_nrect:1};
    vecs[1] = '{c:'{100, 40, 10, 30}, w:-1, last:0, out:0, exp_data:0, exp_nrect:0};
    vecs[2] = '{c:'{50, 10, 5, 20},   w:2,  last:1, out:1, exp_data:40960, exp_nrect:2};
    vecs[3] = '{c:'{1, 0, 0, 0},      w:1,  last:0, out:0, exp_data:0, exp_nrect:0};
    vecs[4] = '{c:'{1, 0, 0, 0},      w:1,  last:0, out:0, exp_data:0, exp_nrect:0};
    vecs[5] = '{c:'{1, 0, 0, 0},      w:1,  last:0, out:1, exp_data:12288, exp_nrect:3};
    vecs[6] = '{c:'{7, 0, 0, 2},      w:3,  last:1, out:1, exp_data:61440, exp_nrect:1};
    vecs[7] = '{c:'{262143, 0, 262143, 0}, w:-4, last:1, out:1, exp_data:-64'sd8589901824,
                exp_nrect:1};
    vecs[8] = '{c:'{0, 5, 0, 0},      w:3,  last:1, out:1, exp_data:-61440, exp_nrect:1};

    din_valid = 1'b0; din_data = '0; din_last = 1'b0;
    weight_valid = 1'b0; weight = '0; dout_ready = 1'b1;
    do_reset();

    @(negedge clk);
    check("rst_din_ready", longint'(din_ready), 1);
    check("rst_weight_ready", longint'(weight_ready), 0);
    check("rst_dout_valid", longint'(dout_valid), 0);
    check("rst_dout_data", longint'(dout_data), 0);
    check("rst_dout_nrect", longint'(dout_nrect), 0);
    check("rst_err", longint'(err), 0);
    @(posedge clk);
    #1;

    // Table: weight always offered, output always accepted.
    weight_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      weight = 3'(vecs[i].w);
      if (vecs[i].out) exp_q.push_back('{data: vecs[i].exp_data, nrect: vecs[i].exp_nrect});
      for (int k = 0; k < 3; k++) send_corner(vecs[i].c[k], 1'b0);
      send_corner(vecs[i].c[3], vecs[i].last);
      check("latency_dout_valid", longint'(dout_valid), longint'(vecs[i].out));
    end
    idle();
    drain();
    check("err_clean", longint'(err), 0);

    // Backpressure: second feature stalls only at its final corner D.
    dout_ready = 1'b0;
    weight = 3'sd1;
    exp_q.push_back('{data: 20480, nrect: 1});
    exp_q.push_back('{data: 12288, nrect: 1});
    send_corner(9, 0); send_corner(2, 0); send_corner(0, 0); send_corner(2, 1);
    held = longint'(dout_data);
    check("bp_first_value", held, 20480);
    send_corner(3, 0); send_corner(0, 0); send_corner(0, 0);
    din_valid = 1'b1; din_data = '0; din_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_din_ready", longint'(din_ready), 0);
      check("bp_dout_hold", longint'(dout_data), held);
      @(posedge clk);
      #1;
    end
    dout_ready = 1'b1;
    send_corner(0, 1);
    check("bp_reload_valid", longint'(dout_valid), 1);
    idle();
    drain();

    // Weight starvation at corner D.
    weight_valid = 1'b0;
    weight = -3'sd2;
    exp_q.push_back('{data: -40960, nrect: 1});
    send_corner(6, 0); send_corner(1, 0); send_corner(0, 0);
    din_valid = 1'b1; din_data = 18'd0; din_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ws_din_ready", longint'(din_ready), 0);
      check("ws_weight_ready", longint'(weight_ready), 0);
      @(posedge clk);
      #1;
    end
    weight_valid = 1'b1;
    @(negedge clk);
    check("ws_weight_ready_go", longint'(weight_ready), 1);
    @(posedge clk);
    #1;
    idle();
    drain();

    // Reset after corner B discards the partial feature.
    weight = 3'sd1;
    send_corner(500, 0); send_corner(1, 0);
    idle();
    do_reset();
    exp_q.push_back('{data: 8192, nrect: 1});
    send_corner(4, 0); send_corner(1, 0); send_corner(0, 0); send_corner(1, 1);
    idle();
    drain();
    check("rst_mid_err", longint'(err), 0);

    // din_last on corner B is ignored for sequencing but sets err.
    exp_q.push_back('{data: 4096, nrect: 1});
    send_corner(3, 0); send_corner(1, 1); send_corner(0, 0); send_corner(1, 1);
    idle();
    drain();
    check("err_set", longint'(err), 1);
    do_reset();
    @(negedge clk);
    check("err_cleared", longint'(err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
